// File: rtl/up_bus_arb_if.sv
// Bundle between the requesters, the up_bus_arb arbiter and the downstream local bus.
// The master modport is the arbiter's view. The slave modport is the environment's view.
interface up_bus_arb_if #(
  parameter int NREQ   = 2,
  parameter int G_CPUA = 30,
  parameter int G_CPUW = 32
);
  logic [NREQ-1:0]        req_upen;
  logic [NREQ-1:0]        req_rnw;
  logic [NREQ*G_CPUA-1:0] req_upa;
  logic [NREQ*G_CPUW-1:0] req_updi;
  logic [G_CPUW-1:0]      req_updo;
  logic [NREQ-1:0]        req_uprdy;
  logic [NREQ-1:0]        req_uperr;
  logic [G_CPUA-1:0]      upa;
  logic [G_CPUW-1:0]      updi;
  logic                   upen;
  logic                   upws;
  logic                   uprs;
  logic [G_CPUW-1:0]      updo;
  logic                   uprdy;
  logic [NREQ-1:0]        gnt;

  modport master (
    input  req_upen, req_rnw, req_upa, req_updi, updo, uprdy,
    output req_updo, req_uprdy, req_uperr, upa, updi, upen, upws, uprs, gnt
  );

  modport slave (
    output req_upen, req_rnw, req_upa, req_updi, updo, uprdy,
    input  req_updo, req_uprdy, req_uperr, upa, updi, upen, upws, uprs, gnt
  );
endinterface

// File: rtl/up_bus_arb.sv
// Round-robin arbiter that lets NREQ requesters share one local bus.
// A transaction that the bus does not complete is ended by a timeout, and the requester gets an error.
module up_bus_arb #(
  parameter int                NREQ      = 2,
  parameter int                G_CPUA    = 30,
  parameter int                G_CPUW    = 32,
  parameter int                TOUT_W    = 8,
  parameter logic [G_CPUW-1:0] TIMEOUT_D = 32'hCAFE_CAFE
) (
  input logic          clk,
  input logic          rst_n,
  up_bus_arb_if.master bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [TOUT_W-1:0] TCNT_ONE  = {{(TOUT_W-1){1'b0}}, 1'b1};
  localparam logic [TOUT_W-1:0] TCNT_LAST = {TOUT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IW-1:0]     r_last;
  logic [IW-1:0]     r_gidx;
  logic [IW-1:0]     w_win;
  logic              w_any;
  logic              w_grant;
  logic              w_done;
  logic              w_tout;
  logic [TOUT_W-1:0] r_tcnt;
  logic              r_upen;
  logic              r_upws;
  logic              r_uprs;
  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   r_req_uprdy;
  logic [NREQ-1:0]   r_req_uperr;
  logic [G_CPUW-1:0] r_req_updo;

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
    onehot = {{(NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Round-robin search: walk downward so that the nearest offset after r_last is assigned last and wins
  always_comb begin
    int k;
    w_any = 1'b0;
    w_win = r_last;
    for (int s = NREQ; s >= 1; s--) begin
      k     = (int'(r_last) + s) % NREQ;
      w_win = bus.req_upen[IW'(k)] ? IW'(k) : w_win;
      w_any = w_any | bus.req_upen[IW'(k)];
    end
  end

  // Next-state logic; a downstream ready takes priority over a timeout in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_done      = 1'b0;
    w_tout      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_ACCESS;
          w_grant     = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (bus.uprdy) begin
          w_state_nxt = S_RELEASE;
          w_done      = 1'b1;
        end else if (r_tcnt == TCNT_LAST) begin
          w_state_nxt = S_RELEASE;
          w_done      = 1'b1;
          w_tout      = 1'b1;
        end else begin
          w_state_nxt = S_ACCESS;
        end
      end
      S_RELEASE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant bookkeeping, timeout counter and registered bus/requester outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last      <= IW'(NREQ - 1);
      r_gidx      <= {IW{1'b0}};
      r_tcnt      <= {TOUT_W{1'b0}};
      r_upen      <= 1'b0;
      r_upws      <= 1'b0;
      r_uprs      <= 1'b0;
      r_gnt       <= {NREQ{1'b0}};
      r_req_uprdy <= {NREQ{1'b0}};
      r_req_uperr <= {NREQ{1'b0}};
      r_req_updo  <= {G_CPUW{1'b0}};
    end else begin
      r_upws      <= 1'b0;
      r_uprs      <= 1'b0;
      r_req_uprdy <= {NREQ{1'b0}};
      r_req_uperr <= {NREQ{1'b0}};
      if (w_grant) begin
        r_last <= w_win;
        r_gidx <= w_win;
        r_gnt  <= onehot(w_win);
        r_upen <= 1'b1;
        r_upws <= ~bus.req_rnw[w_win];
        r_uprs <= bus.req_rnw[w_win];
        r_tcnt <= {TOUT_W{1'b0}};
      end else if (w_done) begin
        r_upen      <= 1'b0;
        r_gnt       <= {NREQ{1'b0}};
        r_req_uprdy <= onehot(r_gidx);
        r_req_uperr <= w_tout ? onehot(r_gidx) : {NREQ{1'b0}};
        r_req_updo  <= w_tout ? TIMEOUT_D : bus.updo;
      end else if (r_state == S_ACCESS) begin
        r_tcnt <= r_tcnt + TCNT_ONE;
      end else begin
        r_tcnt <= r_tcnt;
      end
    end
  end

  assign bus.upen      = r_upen;
  assign bus.upws      = r_upws;
  assign bus.uprs      = r_uprs;
  assign bus.gnt       = r_gnt;
  assign bus.req_uprdy = r_req_uprdy;
  assign bus.req_uperr = r_req_uperr;
  assign bus.req_updo  = r_req_updo;
  assign bus.upa       = bus.req_upa[int'(r_gidx)*G_CPUA +: G_CPUA];
  assign bus.updi      = bus.req_updi[int'(r_gidx)*G_CPUW +: G_CPUW];
endmodule
